// File: rtl/store_queue_if.sv
// store_queue_if: groups the store queue's pipeline, ROB, load-lookup and
// cache signals into one bundle.
//   master : the pipeline, ROB and cache side; drives the in_* signals
//   slave  : the store queue; drives the out_* signals
// clk and reset are not part of the bundle.
interface store_queue_if #(
  parameter int SQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 4
);
  localparam int PTR_W = $clog2(SQ_DEPTH);

  // store allocation
  logic                 in_store_valid;
  logic [31:0]          in_addr;
  logic [31:0]          in_data;
  logic [2:0]           in_funct3;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 out_stall;
  // load forwarding lookup
  logic                 in_load_valid;
  logic [31:0]          in_load_addr;
  logic [2:0]           in_load_funct3;
  logic                 out_fwd_hit;
  logic [31:0]          out_fwd_data;
  logic                 out_load_stall;
  // commit / flush
  logic                 in_commit_valid;
  logic [ROB_IDX_W-1:0] in_commit_rob_idx;
  logic                 in_flush;
  // cache drain
  logic                 out_cache_req;
  logic [31:0]          out_cache_addr;
  logic [31:0]          out_cache_data;
  logic [2:0]           out_cache_funct3;
  logic                 in_cache_ready;
  // status
  logic [PTR_W:0]       out_count;
  logic                 out_empty;

  modport master (
    output in_store_valid, in_addr, in_data, in_funct3, in_rob_idx,
    output in_load_valid, in_load_addr, in_load_funct3,
    output in_commit_valid, in_commit_rob_idx, in_flush, in_cache_ready,
    input  out_stall, out_fwd_hit, out_fwd_data, out_load_stall,
    input  out_cache_req, out_cache_addr, out_cache_data, out_cache_funct3,
    input  out_count, out_empty
  );

  modport slave (
    input  in_store_valid, in_addr, in_data, in_funct3, in_rob_idx,
    input  in_load_valid, in_load_addr, in_load_funct3,
    input  in_commit_valid, in_commit_rob_idx, in_flush, in_cache_ready,
    output out_stall, out_fwd_hit, out_fwd_data, out_load_stall,
    output out_cache_req, out_cache_addr, out_cache_data, out_cache_funct3,
    output out_count, out_empty
  );
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order circular store queue between the memory stage and
// the data cache.
// - Stores are allocated at the tail and tagged with their ROB index.
// - The ROB commits stores. Committed stores drain from the head to the
//   cache over a ready/valid handshake.
// - Loads get combinational store-to-load forwarding from the youngest
//   overlapping store.
// - A flush drops every uncommitted entry.
// Ports:
//   clk   : clock; all state updates on the rising edge
//   reset : asynchronous, active-high
//   sq    : store_queue_if.slave; the allocate, load, commit/flush,
//           cache and status signals
module store_queue #(
  parameter int SQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_queue_if.slave   sq
);
  localparam int PTR_W = $clog2(SQ_DEPTH);

  logic [31:0]          r_addr      [SQ_DEPTH];
  logic [31:0]          r_data      [SQ_DEPTH];
  logic [2:0]           r_funct3    [SQ_DEPTH];
  logic [ROB_IDX_W-1:0] r_rob       [SQ_DEPTH];
  logic [SQ_DEPTH-1:0]  r_valid;
  logic [SQ_DEPTH-1:0]  r_committed;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;

  logic                 w_full;
  logic                 w_alloc;
  logic                 w_req;
  logic                 w_xfer;
  logic [SQ_DEPTH-1:0]  w_cmt_hit;
  logic [SQ_DEPTH-1:0]  w_cmt_nxt;
  logic [PTR_W:0]       w_ccnt;
  logic [PTR_W-1:0]     w_tail_nxt;
  logic [PTR_W:0]       w_count_nxt;

  logic [3:0]           w_lmask;
  logic [3:0]           w_smask;
  logic [PTR_W-1:0]     w_scan;
  logic [PTR_W-1:0]     w_sel;
  logic                 w_found;
  logic                 w_cover;
  logic [31:0]          w_sword;
  logic [31:0]          w_lword;
  logic [31:0]          w_ext;

  // Byte lanes touched by an access; sub-word accesses are aligned down.
  function automatic logic [3:0] f_mask(input logic [1:0] lo, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: f_mask = 4'b0001 << lo;
      3'b001, 3'b101: f_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:        f_mask = 4'b1111;
    endcase
  endfunction

  // Byte offset of the lowest lane of an access.
  function automatic logic [1:0] f_off(input logic [1:0] lo, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: f_off = lo;
      3'b001, 3'b101: f_off = {lo[1], 1'b0};
      default:        f_off = 2'b00;
    endcase
  endfunction

  // A full queue drops the store even if the head drains this cycle, and
  // a flush drops any store offered in the same cycle.
  assign w_full  = (r_count == (PTR_W+1)'(SQ_DEPTH));
  assign w_alloc = sq.in_store_valid && !w_full && !sq.in_flush;
  assign w_req   = r_valid[r_head] && r_committed[r_head];
  assign w_xfer  = w_req && sq.in_cache_ready;

  // Commit is resolved before flush, so a store committed in the flush
  // cycle survives. Committed entries are contiguous from the head, so
  // their count gives the new tail position after a flush.
  always_comb begin
    w_cmt_hit = '0;
    w_cmt_nxt = '0;
    w_ccnt    = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      w_cmt_hit[i] = sq.in_commit_valid && r_valid[i] && !r_committed[i] &&
                     (r_rob[i] == sq.in_commit_rob_idx);
      w_cmt_nxt[i] = r_committed[i] | w_cmt_hit[i];
      if (r_valid[i] && w_cmt_nxt[i]) w_ccnt = w_ccnt + 1'b1;
    end
  end

  always_comb begin
    w_tail_nxt  = r_tail + PTR_W'(w_alloc);
    w_count_nxt = r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_xfer);
    if (sq.in_flush) begin
      w_tail_nxt  = r_head + w_ccnt[PTR_W-1:0];
      w_count_nxt = w_ccnt - (PTR_W+1)'(w_xfer);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_committed <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_addr[i]   <= '0;
        r_data[i]   <= '0;
        r_funct3[i] <= '0;
        r_rob[i]    <= '0;
      end
    end else begin
      r_head  <= r_head + PTR_W'(w_xfer);
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (w_alloc && (r_tail == PTR_W'(i))) begin
          r_addr[i]      <= sq.in_addr;
          r_data[i]      <= sq.in_data;
          r_funct3[i]    <= sq.in_funct3;
          r_rob[i]       <= sq.in_rob_idx;
          r_valid[i]     <= 1'b1;
          r_committed[i] <= 1'b0;
        end else begin
          if (w_cmt_hit[i]) r_committed[i] <= 1'b1;
          if (w_xfer && (r_head == PTR_W'(i))) begin
            r_valid[i]     <= 1'b0;
            r_committed[i] <= 1'b0;
          end else if (sq.in_flush && !w_cmt_nxt[i]) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Forwarding scan: walk oldest to youngest so the last match wins, which
  // makes the youngest overlapping entry the selected one.
  always_comb begin
    w_lmask = f_mask(sq.in_load_addr[1:0], sq.in_load_funct3);
    w_found = 1'b0;
    w_sel   = r_head;
    w_scan  = r_head;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      w_scan = r_head + PTR_W'(k);
      if ((k < int'(r_count)) && r_valid[w_scan] &&
          (r_addr[w_scan][31:2] == sq.in_load_addr[31:2]) &&
          (|(f_mask(r_addr[w_scan][1:0], r_funct3[w_scan]) & w_lmask))) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
    end
  end

  always_comb begin
    w_smask = f_mask(r_addr[w_sel][1:0], r_funct3[w_sel]);
    w_cover = ((w_lmask & ~w_smask) == 4'b0000);
    // place store data in its memory lanes, then bring the load's lanes down
    w_sword = r_data[w_sel] << {f_off(r_addr[w_sel][1:0], r_funct3[w_sel]), 3'b000};
    w_lword = w_sword >> {f_off(sq.in_load_addr[1:0], sq.in_load_funct3), 3'b000};
    case (sq.in_load_funct3)
      3'b000:  w_ext = {{24{w_lword[7]}}, w_lword[7:0]};
      3'b001:  w_ext = {{16{w_lword[15]}}, w_lword[15:0]};
      3'b100:  w_ext = {24'h000000, w_lword[7:0]};
      3'b101:  w_ext = {16'h0000, w_lword[15:0]};
      default: w_ext = w_lword;
    endcase
  end

  assign sq.out_fwd_hit      = sq.in_load_valid && w_found && w_cover;
  assign sq.out_load_stall   = sq.in_load_valid && w_found && !w_cover;
  assign sq.out_fwd_data     = sq.out_fwd_hit ? w_ext : 32'h0;

  assign sq.out_stall        = sq.in_store_valid && w_full;
  assign sq.out_cache_req    = w_req;
  assign sq.out_cache_addr   = r_addr[r_head];
  assign sq.out_cache_data   = r_data[r_head];
  assign sq.out_cache_funct3 = r_funct3[r_head];
  assign sq.out_count        = r_count;
  assign sq.out_empty        = (r_count == '0);
endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  logic clk;
  logic reset;

  store_queue_if #(.SQ_DEPTH(8), .ROB_IDX_W(4)) sqi ();

  store_queue #(.SQ_DEPTH(8), .ROB_IDX_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sq    (sqi.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cache-write monitor: a handshake seen at the falling edge completes on
  // the next rising edge, so compare it against the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && sqi.out_cache_req && sqi.in_cache_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL cache_unexpected: got addr %h data %h, expected no write",
                   sqi.out_cache_addr, sqi.out_cache_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (sqi.out_cache_addr !== mon_e.addr || sqi.out_cache_data !== mon_e.data ||
              sqi.out_cache_funct3 !== mon_e.f3) begin
            n_err++;
            $display("FAIL cache_write: got %h/%h/%b, expected %h/%h/%b",
                     sqi.out_cache_addr, sqi.out_cache_data, sqi.out_cache_funct3,
                     mon_e.addr, mon_e.data, mon_e.f3);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input logic [3:0] rob);
    sqi.in_store_valid = 1'b1;
    sqi.in_addr        = a;
    sqi.in_data        = d;
    sqi.in_funct3      = f3;
    sqi.in_rob_idx     = rob;
    tick();
    sqi.in_store_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.f3   = f3;
    exp_q.push_back(e);
  endtask

  task automatic ld(input string name, input logic [31:0] a, input logic [2:0] f3,
                    input logic e_hit, input logic e_stall, input logic [31:0] e_data);
    sqi.in_load_valid  = 1'b1;
    sqi.in_load_addr   = a;
    sqi.in_load_funct3 = f3;
    #1;
    chk({name, "_hit"},   {31'b0, sqi.out_fwd_hit},    {31'b0, e_hit});
    chk({name, "_stall"}, {31'b0, sqi.out_load_stall}, {31'b0, e_stall});
    chk({name, "_data"},  sqi.out_fwd_data,            e_data);
    sqi.in_load_valid  = 1'b0;
  endtask

  initial begin
    reset                 = 1'b1;
    sqi.in_store_valid    = 1'b0;
    sqi.in_addr           = '0;
    sqi.in_data           = '0;
    sqi.in_funct3         = '0;
    sqi.in_rob_idx        = '0;
    sqi.in_load_valid     = 1'b0;
    sqi.in_load_addr      = '0;
    sqi.in_load_funct3    = '0;
    sqi.in_commit_valid   = 1'b0;
    sqi.in_commit_rob_idx = '0;
    sqi.in_flush          = 1'b0;
    sqi.in_cache_ready    = 1'b0;

    repeat (2) tick();
    chk("rst_count", {28'b0, sqi.out_count}, 32'd0);
    chk("rst_empty", {31'b0, sqi.out_empty}, 32'd1);
    chk("rst_req",   {31'b0, sqi.out_cache_req}, 32'd0);
    chk("rst_stall", {31'b0, sqi.out_stall}, 32'd0);
    reset = 1'b0;
    tick();

    // fill to capacity, then a ninth store is refused
    for (int i = 0; i < 8; i++)
      store(32'h1000 + 32'(i) * 4, 32'hA0 + 32'(i), 3'b010, 4'(i));
    chk("fill_count", {28'b0, sqi.out_count}, 32'd8);
    chk("fill_empty", {31'b0, sqi.out_empty}, 32'd0);
    sqi.in_store_valid = 1'b1;
    sqi.in_addr        = 32'h2000;
    sqi.in_data        = 32'h1234;
    sqi.in_funct3      = 3'b010;
    sqi.in_rob_idx     = 4'd8;
    #1;
    chk("full_stall", {31'b0, sqi.out_stall}, 32'd1);
    tick();
    sqi.in_store_valid = 1'b0;
    chk("full_count", {28'b0, sqi.out_count}, 32'd8);
    ld("full_dropped", 32'h2000, 3'b010, 1'b0, 1'b0, 32'h0);
    ld("fwd_word",     32'h1004, 3'b010, 1'b1, 1'b0, 32'hA1);

    // commit four in order with the cache ready: one write per cycle
    sqi.in_cache_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sqi.in_commit_valid   = 1'b1;
      sqi.in_commit_rob_idx = 4'(i);
      push(32'h1000 + 32'(i) * 4, 32'hA0 + 32'(i), 3'b010);
      tick();
      chk($sformatf("drain_req%0d", i), {31'b0, sqi.out_cache_req}, 32'd1);
    end
    sqi.in_commit_valid = 1'b0;
    tick();
    chk("drain_req_end", {31'b0, sqi.out_cache_req}, 32'd0);
    chk("drain_count",   {28'b0, sqi.out_count}, 32'd4);

    sqi.in_flush = 1'b1;
    tick();
    sqi.in_flush = 1'b0;
    chk("flushA_count", {28'b0, sqi.out_count}, 32'd0);
    chk("flushA_empty", {31'b0, sqi.out_empty}, 32'd1);

    // byte-accurate forwarding
    store(32'h100, 32'hDEADBEEF, 3'b010, 4'd9);
    store(32'h101, 32'h00000055, 3'b000, 4'd10);
    ld("lbu_101", 32'h101, 3'b100, 1'b1, 1'b0, 32'h00000055);
    ld("lb_103",  32'h103, 3'b000, 1'b1, 1'b0, 32'hFFFFFFDE);
    ld("lw_100",  32'h100, 3'b010, 1'b0, 1'b1, 32'h0);
    ld("lh_102",  32'h102, 3'b001, 1'b1, 1'b0, 32'hFFFFDEAD);
    ld("lhu_100", 32'h100, 3'b101, 1'b0, 1'b1, 32'h0);
    ld("lw_200",  32'h200, 3'b010, 1'b0, 1'b0, 32'h0);
    sqi.in_flush = 1'b1;
    tick();
    sqi.in_flush = 1'b0;
    chk("flushB_count", {28'b0, sqi.out_count}, 32'd0);

    // flush keeps committed entries, incl. one committed in the flush cycle
    sqi.in_cache_ready = 1'b0;
    store(32'h300, 32'h11111111, 3'b010, 4'd11);
    store(32'h304, 32'h00002222, 3'b001, 4'd12);
    store(32'h308, 32'h33333333, 3'b010, 4'd13);
    store(32'h30C, 32'h44444444, 3'b010, 4'd14);
    sqi.in_commit_valid   = 1'b1;
    sqi.in_commit_rob_idx = 4'd11;
    push(32'h300, 32'h11111111, 3'b010);
    tick();
    sqi.in_commit_rob_idx = 4'd12;
    push(32'h304, 32'h00002222, 3'b001);
    sqi.in_flush       = 1'b1;
    sqi.in_store_valid = 1'b1;
    sqi.in_addr        = 32'h600;
    sqi.in_data        = 32'h66666666;
    sqi.in_funct3      = 3'b010;
    sqi.in_rob_idx     = 4'd15;
    tick();
    sqi.in_commit_valid = 1'b0;
    sqi.in_flush        = 1'b0;
    sqi.in_store_valid  = 1'b0;
    chk("flushC_count", {28'b0, sqi.out_count}, 32'd2);
    chk("flushC_req",   {31'b0, sqi.out_cache_req}, 32'd1);
    store(32'h400, 32'h0000007E, 3'b000, 4'd0);
    chk("postflush_count", {28'b0, sqi.out_count}, 32'd3);
    ld("lbu_400",   32'h400, 3'b100, 1'b1, 1'b0, 32'h0000007E);
    ld("flushed",   32'h308, 3'b010, 1'b0, 1'b0, 32'h0);
    ld("flush_alc", 32'h600, 3'b010, 1'b0, 1'b0, 32'h0);
    ld("lhu_304",   32'h304, 3'b101, 1'b1, 1'b0, 32'h00002222);
    sqi.in_commit_valid   = 1'b1;
    sqi.in_commit_rob_idx = 4'd0;
    push(32'h400, 32'h0000007E, 3'b000);
    tick();
    sqi.in_commit_valid = 1'b0;
    sqi.in_cache_ready  = 1'b1;
    repeat (4) tick();
    chk("flushC_drained", {28'b0, sqi.out_count}, 32'd0);

    // stream 20 stores through so the pointers wrap
    for (int i = 0; i < 20; i++) begin
      store(32'h800 + 32'(i) * 4, 32'(i) * 32'h01010101, 3'b010, 4'(i));
      sqi.in_commit_valid   = 1'b1;
      sqi.in_commit_rob_idx = 4'(i);
      push(32'h800 + 32'(i) * 4, 32'(i) * 32'h01010101, 3'b010);
      tick();
      sqi.in_commit_valid = 1'b0;
    end
    repeat (3) tick();
    chk("wrap_empty", {31'b0, sqi.out_empty}, 32'd1);
    chk("wrap_count", {28'b0, sqi.out_count}, 32'd0);

    // reset in the middle of a pending drain
    sqi.in_cache_ready = 1'b0;
    store(32'h500, 32'hCAFEF00D, 3'b010, 4'd5);
    sqi.in_commit_valid   = 1'b1;
    sqi.in_commit_rob_idx = 4'd5;
    tick();
    sqi.in_commit_valid = 1'b0;
    chk("pre_rst_req",  {31'b0, sqi.out_cache_req}, 32'd1);
    chk("pre_rst_addr", sqi.out_cache_addr, 32'h500);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_req",   {31'b0, sqi.out_cache_req}, 32'd0);
    chk("async_rst_empty", {31'b0, sqi.out_empty}, 32'd1);
    chk("async_rst_addr",  sqi.out_cache_addr, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    ld("post_rst", 32'h500, 3'b010, 1'b0, 1'b0, 32'h0);

    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
